// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback path.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int STARVE_W    = 4;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {GNT_ALU, GNT_LSU} wb_gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for destinations of outstanding loads; flags RAW hazards in decode.
module rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              stall
);

    logic [NUM_REGS-1:0] busy;

    // Set is applied after clear so a same-register collision leaves the bit set;
    // x0 is forced low last so it can never become busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_rd] <= 1'b0;
            if (set_en) busy[set_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign stall = busy[chk_rs1] | busy[chk_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between ALU and LSU writebacks (ALU priority,
// LSU starvation guard). Optional load scoreboard under RF_SCOREBOARD_EN.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REGS     = RF_NUM_REGS,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    input  logic              issue_load,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                lsu_win;
    logic                xfer;
    wb_gnt_e             gnt;
    wb_req_t             win;

    assign lsu_win = lsu_valid && (!alu_valid || starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign gnt     = lsu_win ? GNT_LSU : GNT_ALU;

    // Grants are masked by reset so nothing is accepted while the port is held in reset.
    assign lsu_ready = rst_n && lsu_win;
    assign alu_ready = rst_n && alu_valid && !lsu_win;
    assign xfer      = alu_ready || lsu_ready;

    always_comb begin
        win.rd   = alu_rd;
        win.data = alu_data;
        if (gnt == GNT_LSU) begin
            win.rd   = lsu_rd;
            win.data = lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!lsu_valid || lsu_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // x0 writes still complete the handshake but never reach the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && (win.rd != '0);
            if (xfer) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue_load),
        .set_rd  (issue_rd),
        .clr_en  (lsu_ready),
        .clr_rd  (lsu_rd),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .stall   (stall)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{issue_load, issue_rd, chk_rs1, chk_rs2};
    assign stall     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases plus random traffic
// checked against a cycle-level reference model of grants, writes and busy bits.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;
`ifdef RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk, rst_n;
    logic        alu_valid, lsu_valid, issue_load;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_load(issue_load), .issue_rd(issue_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        we;
        bit [4:0]  a;
        bit [31:0] d;
    } exp_t;

    exp_t      exp_q[$];
    int        total = 0;
    int        bad   = 0;
    bit [31:0] busy_m;
    int        wait_m;
    bit        alu_done, lsu_done, model_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin : model
        bit   ag, lg;
        exp_t e;
        if (rst_n && model_en) begin
            lg = lsu_valid && (!alu_valid || wait_m == LIMIT);
            ag = alu_valid && !lg;
            chk("alu_ready", alu_ready, ag);
            chk("lsu_ready", lsu_ready, lg);
            chk("stall", stall, SB & (busy_m[chk_rs1] | busy_m[chk_rs2]));
            e.we = 1'b0; e.a = '0; e.d = '0;
            if (ag) begin e.we = (alu_rd != 0); e.a = alu_rd; e.d = alu_data; end
            if (lg) begin e.we = (lsu_rd != 0); e.a = lsu_rd; e.d = lsu_data; end
            exp_q.push_back(e);
            if (lsu_valid && !lg) wait_m = (wait_m < 15) ? wait_m + 1 : 15;
            else                  wait_m = 0;
            if (lg) busy_m[lsu_rd] = 1'b0;
            if (issue_load && issue_rd != 0) busy_m[issue_rd] = 1'b1;
            alu_done = ag;
            lsu_done = lg;
        end
    end

    // Monitor: every modelled cycle owes exactly one registered write-port state.
    always @(posedge clk) begin : monitor
        exp_t e;
        #3;
        if (rst_n && model_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", rf_we, e.we);
            if (e.we) begin
                chk("rf_waddr", rf_waddr, e.a);
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; lsu_valid = 0; issue_load = 0;
        alu_rd = 0; lsu_rd = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        alu_data = 0; lsu_data = 0;
    endtask

    task automatic reset_model();
        exp_q.delete();
        busy_m = '0; wait_m = 0; alu_done = 0; lsu_done = 0;
    endtask

    initial begin
        idle();
        model_en = 0;
        reset_model();
        rst_n = 0;
        alu_valid = 1; lsu_valid = 1;
        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_stall", stall, 0);
        step(); idle(); step();
        rst_n = 1; model_en = 1;

        // ALU only
        step();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        mid(); chk("alu_only_ready", alu_ready, 1);
        step(); idle(); #2;
        chk("alu_only_we", rf_we, 1);
        chk("alu_only_addr", rf_waddr, 5);
        chk("alu_only_data", rf_wdata, 32'hDEADBEEF);
        step(); #2; chk("alu_only_we_off", rf_we, 0);

        // Contention: ALU first, then LSU
        step();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        mid(); chk("cont_alu_g", alu_ready, 1); chk("cont_lsu_w", lsu_ready, 0);
        step(); alu_valid = 0; #2; chk("cont_x3", rf_waddr, 3);
        mid(); chk("cont_lsu_g", lsu_ready, 1);
        step(); idle(); #2;
        chk("cont_x4_we", rf_we, 1); chk("cont_x4", rf_waddr, 4); chk("cont_x4_d", rf_wdata, 32'h22);

        // Starvation: both valid continuously
        step();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hAA;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk("starve_alu", alu_ready, c != 4);
            chk("starve_lsu", lsu_ready, c == 4);
            step();
            alu_data = 32'h100 + c + 1;
            if (c == 4) lsu_data = 32'hBB;
        end
        idle();

        // x0 write from LSU
        step();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFFFFFF;
        mid(); chk("x0_ready", lsu_ready, 1);
        step(); idle(); #2; chk("x0_we", rf_we, 0);

        // Scoreboard set / clear / collision
        step();
        issue_load = 1; issue_rd = 7; chk_rs1 = 7;
        mid(); chk("sb_stall_n", stall, 0);
        step(); issue_load = 0;
        mid(); chk("sb_stall_n1", stall, SB);
        step(); step();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        mid(); chk("sb_clr_ready", lsu_ready, 1); chk("sb_stall_n3", stall, SB);
        step(); lsu_valid = 0;
        mid(); chk("sb_stall_n4", stall, 0);
        step();
        issue_load = 1; issue_rd = 7;
        step();
        issue_load = 1; issue_rd = 7; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h78;
        step(); idle(); chk_rs2 = 7;
        mid(); chk("sb_collide", stall, SB);
        step(); lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h79;
        step(); idle();

        // Reset the cycle after an ALU transfer
        step();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; issue_load = 1; issue_rd = 12;
        step(); idle(); chk_rs1 = 12;
        rst_n = 0; model_en = 0; reset_model();
        alu_valid = 1; lsu_valid = 1;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_alu", alu_ready, 0);
        chk("mid_rst_lsu", lsu_ready, 0);
        chk("mid_rst_stall", stall, 0);
        step(); step(); idle();
        rst_n = 1; model_en = 1;
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA5;
        mid(); chk("post_rst_ready", alu_ready, 1);
        step(); idle(); #2;
        chk("post_rst_we", rf_we, 1); chk("post_rst_addr", rf_waddr, 10);

        // Random traffic under the hold-until-transfer rule
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!alu_valid || alu_done) begin
                alu_valid = ($urandom % 100) < 75;
                alu_rd = 5'($urandom); alu_data = $urandom;
            end
            if (!lsu_valid || lsu_done) begin
                lsu_valid = ($urandom % 100) < 50;
                lsu_rd = 5'($urandom); lsu_data = $urandom;
            end
            issue_load = ($urandom % 4) == 0;
            issue_rd = 5'($urandom);
            chk_rs1 = 5'($urandom);
            chk_rs2 = 5'($urandom);
        end
        step(); idle();
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
